// File: rtl/ps2_keybuf_if.sv
// ps2_keybuf_if -- bundle of the keyboard code buffer's data/handshake signals.
//
// master : producer/consumer side (drives codes, pop requests, overflow clear)
// slave  : the buffer itself
//
// Signals
//   in_data   [7:0]  ASCII code from the PS/2 decoder, 8'h00 = unmapped key
//   in_valid         one-cycle strobe qualifying in_data
//   rd_en            pop request
//   clr_ovf          one-cycle strobe clearing the overflow flag
//   rd_data   [7:0]  oldest stored code (show-ahead)
//   empty / full     occupancy flags
//   count     [AW:0] occupancy, 0..DEPTH
//   overflow         sticky "code dropped because full" flag
//   key_total [15:0] running count of accepted codes, wraps
interface ps2_keybuf_if #(
  parameter int unsigned AW = 3
);
  logic [7:0]  in_data;
  logic        in_valid;
  logic        rd_en;
  logic        clr_ovf;
  logic [7:0]  rd_data;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        overflow;
  logic [15:0] key_total;

  modport master (
    output in_data,
    output in_valid,
    output rd_en,
    output clr_ovf,
    input  rd_data,
    input  empty,
    input  full,
    input  count,
    input  overflow,
    input  key_total
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  rd_en,
    input  clr_ovf,
    output rd_data,
    output empty,
    output full,
    output count,
    output overflow,
    output key_total
  );
endinterface

// File: rtl/ps2_keybuf.sv
// ps2_keybuf -- show-ahead FIFO buffering ASCII key codes from a PS/2 decoder.
//
// Unmapped keys (code 8'h00) are filtered out. Codes arriving while the buffer
// is full are dropped and latch a sticky overflow flag, unless a pop happens in
// the same cycle, in which case both the pop and the write take place.
// key_total counts every code actually stored.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (clears pointers, count, flags,
//          key_total; storage array is not cleared)
//   bus    ps2_keybuf_if.slave -- data, handshake and status signals
//
// Parameters
//   DEPTH  entry count, power of two in 2..256
//   AW     pointer width, must equal log2(DEPTH)
module ps2_keybuf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  ps2_keybuf_if.slave   bus
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  // Storage and state
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   key_total_q, key_total_d;

  // Decoded events
  logic empty;
  logic full;
  logic wr_req;    // valid, mapped code offered
  logic pop;       // pop actually performed
  logic wr;        // code actually stored
  logic ovf_set;   // code dropped because full

  // Flags come from the registered count only, so no input reaches them.
  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  always_comb begin
    wr_req  = bus.in_valid && (bus.in_data != 8'h00);
    pop     = bus.rd_en && !empty;
    // A same-cycle pop frees the slot the write needs when full.
    wr      = wr_req && (!full || pop);
    ovf_set = wr_req && full && !pop;
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    key_total_d = key_total_q;

    if (wr) begin
      wptr_d      = wptr_q + AW'(1);
      key_total_d = key_total_q + 16'd1;
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end

    unique case ({wr, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    // Setting wins over a same-cycle clear so a drop is never lost.
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      key_total_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      key_total_q <= key_total_d;
    end
  end

  // Storage is deliberately not reset; the write is gated by reset so that
  // inputs held during reset leave no trace.
  always_ff @(posedge clk) begin
    if (wr && reset) begin
      mem[wptr_q] <= bus.in_data;
    end
  end

  assign bus.rd_data   = mem[rptr_q];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.key_total = key_total_q;

endmodule

// File: tb/tb_ps2_keybuf.sv
module tb_ps2_keybuf;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_keybuf_if #(.AW(AW)) kb_if ();

  ps2_keybuf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kb_if)
  );

  // Reference model: buffer contents as a plain queue.
  logic [7:0]  mq [$];
  bit          m_ovf;
  int unsigned m_kt;

  // Scoreboard of codes expected on rd_data at each pop.
  logic [7:0]  exp_q [$];
  bit          mon_en;

  int n_chk;
  int n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: state checks every cycle, rd_data checked whenever a pop is presented.
  always @(negedge clk) begin
    if (mon_en && reset) begin
      chk("count", 32'(kb_if.count), 32'(mq.size()));
      chk("empty", 32'(kb_if.empty), 32'(mq.size() == 0));
      chk("full", 32'(kb_if.full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(kb_if.overflow), 32'(m_ovf));
      chk("key_total", 32'(kb_if.key_total), m_kt);
      if (kb_if.rd_en && !kb_if.empty) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL pop_unexpected: DUT popped %0h, scoreboard expected no pop",
                   kb_if.rd_data);
        end else begin
          chk("rd_data", 32'(kb_if.rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic c);
    bit pop, wr_req, can_store;
    kb_if.in_valid = v;
    kb_if.in_data  = d;
    kb_if.rd_en    = r;
    kb_if.clr_ovf  = c;
    pop = r && (mq.size() > 0);
    if (pop) exp_q.push_back(mq[0]);
    @(posedge clk);
    wr_req    = v && (d != 8'h00);
    can_store = (mq.size() < DEPTH) || pop;
    if (pop) void'(mq.pop_front());
    if (wr_req && can_store) begin
      mq.push_back(d);
      m_kt = (m_kt + 1) % 65536;
    end
    if (wr_req && !can_store) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic scramble_inputs();
    kb_if.in_valid = 1'($urandom);
    kb_if.in_data  = 8'($urandom);
    kb_if.rd_en    = 1'($urandom);
    kb_if.clr_ovf  = 1'($urandom);
  endtask

  // Asynchronous reset mid-cycle; checks take effect before any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    scramble_inputs();
    #1;
    chk("reset_async_empty", 32'(kb_if.empty), 32'd1);
    chk("reset_async_count", 32'(kb_if.count), 32'd0);
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_kt  = 0;
    repeat (2) begin
      @(posedge clk);
      scramble_inputs();
    end
    #1;
    kb_if.in_valid = 1'b0;
    kb_if.in_data  = 8'h00;
    kb_if.rd_en    = 1'b0;
    kb_if.clr_ovf  = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    mon_en = 1'b0;
    m_ovf  = 1'b0;
    m_kt   = 0;
    scramble_inputs();
    repeat (3) begin
      @(posedge clk);
      scramble_inputs();
    end
    #1;
    kb_if.in_valid = 1'b0;
    kb_if.in_data  = 8'h00;
    kb_if.rd_en    = 1'b0;
    kb_if.clr_ovf  = 1'b0;
    reset  = 1'b1;
    mon_en = 1'b1;
    idle();
    chk("post_reset_empty", 32'(kb_if.empty), 32'd1);
    chk("post_reset_count", 32'(kb_if.count), 32'd0);
    chk("post_reset_ovf", 32'(kb_if.overflow), 32'd0);
    chk("post_reset_kt", 32'(kb_if.key_total), 32'd0);

    // Order
    cycle(1'b1, 8'h71, 1'b0, 1'b0);
    chk("latency_show_ahead", 32'(kb_if.rd_data), 32'h71);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 8'h65, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("order_empty", 32'(kb_if.empty), 32'd1);
    chk("order_kt", 32'(kb_if.key_total), 32'd3);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);  // pop while empty is ignored

    // Zero filter from fresh reset
    do_reset();
    repeat (4) cycle(1'b1, 8'h00, 1'b0, 1'b0);
    idle();
    chk("zero_count", 32'(kb_if.count), 32'd0);
    chk("zero_kt", 32'(kb_if.key_total), 32'd0);
    chk("zero_ovf", 32'(kb_if.overflow), 32'd0);

    // Overflow
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    chk("ovf_full", 32'(kb_if.full), 32'd1);
    chk("ovf_count", 32'(kb_if.count), 32'd8);
    chk("ovf_flag", 32'(kb_if.overflow), 32'd1);
    chk("ovf_kt", 32'(kb_if.key_total), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_pop_seq", 32'(kb_if.rd_data), 32'(8'h61 + i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("ovf_69_absent", 32'(kb_if.empty), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(kb_if.overflow), 32'd0);

    // Simultaneous write+pop when full
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h0d, 1'b1, 1'b0);
    chk("simul_count", 32'(kb_if.count), 32'd8);
    chk("simul_ovf", 32'(kb_if.overflow), 32'd0);
    repeat (7) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("simul_8th", 32'(kb_if.rd_data), 32'h0d);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h41, 1'b1, 1'b0);  // write + rd_en while empty
    chk("empty_wr_rd_count", 32'(kb_if.count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Overflow set beats clear in the same cycle
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    chk("ovf_priority", 32'(kb_if.overflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr_alone", 32'(kb_if.overflow), 32'd0);
    repeat (8) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Stream of 20 codes with interleaved pops, then reset mid-stream
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'($urandom_range(1, 255)), 1'($urandom), 1'b0);
    end
    do_reset();

    // Randomised traffic with phases biased toward filling and draining
    for (int ph = 0; ph < 12; ph++) begin
      for (int i = 0; i < 100; i++) begin
        logic [7:0] d;
        d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        cycle(1'($urandom_range(0, 99) < ((ph % 2) ? 30 : 80)), d,
              1'($urandom_range(0, 99) < ((ph % 2) ? 80 : 35)),
              1'($urandom_range(0, 15) == 0));
      end
    end
    repeat (DEPTH + 1) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_keybuf.md
PS2_KEYBUF -- requirements
Module: ps2_keybuf

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; SHALL be a power of two, 2..256.
REQ-002 Parameter AW, default 3, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; SHALL take effect immediately when low, independent of clk.
REQ-005 in_data  input  8  ASCII code from the upstream PS/2 decoder; 8'h00 means an unmapped key.
REQ-006 in_valid  input  1  one-cycle strobe qualifying in_data.
REQ-007 rd_en  input  1  consumer pop request.
REQ-008 clr_ovf  input  1  one-cycle strobe that clears the overflow flag.
REQ-009 rd_data  output  8  oldest stored code (show-ahead).
REQ-010 empty  output  1  FIFO holds 0 entries.
REQ-011 full  output  1  FIFO holds DEPTH entries.
REQ-012 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: a valid code was dropped because the FIFO was full.
REQ-014 key_total  output  16  running count of accepted codes; wraps from 16'hFFFF to 0.

Function
REQ-015 Write event: in_valid=1 and in_data!=8'h00; SHALL be the only condition that can store data.
REQ-016 in_valid with in_data=8'h00 SHALL be discarded: no pointer change, no overflow, no key_total change.
REQ-017 Accepted write: mem[wptr]<=in_data, wptr<=wptr+1 mod DEPTH, key_total<=key_total+1.
REQ-018 Pop event: rd_en=1 and empty=0; rptr<=rptr+1 mod DEPTH.
REQ-019 rd_en while empty SHALL be ignored: no pointer change, no error flag.
REQ-020 rd_data SHALL be mem[rptr], combinationally; value is don't-care while empty=1.
REQ-021 A code written in cycle N SHALL appear on rd_data with empty=0 in cycle N+1 (one-cycle latency).
REQ-022 count SHALL be +1 on write only, -1 on pop only, and unchanged on simultaneous write and pop.
REQ-023 empty SHALL equal (count==0); full SHALL equal (count==DEPTH); both are derived from registered count, with no combinational path from inputs.
REQ-024 Write while full without a same-cycle pop: the code SHALL be dropped, overflow<=1, and key_total SHALL stay unchanged.
REQ-025 Write while full with a same-cycle pop: both SHALL occur, count stays DEPTH, overflow is unchanged, and key_total increments.
REQ-026 Write while empty with same-cycle rd_en: only the write SHALL occur, so count becomes 1.
REQ-027 Overflow priority: a set event beats clr_ovf in the same cycle (overflow stays 1); clr_ovf alone clears it.
REQ-028 The FIFO SHALL preserve arrival order across pointer wrap-around.

Reset
REQ-029 While reset=0: wptr=0, rptr=0, count=0, empty=1, full=0, overflow=0, key_total=0.
REQ-030 mem contents SHALL NOT be reset; rd_data is undefined until the first write.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; the first cycle after release SHALL behave as a fresh start.
REQ-032 Inputs SHALL be ignored while reset=0.

Verification
REQ-033 Post-reset: any inputs held during reset -> after release, empty=1, count=0, overflow=0, key_total=0.
REQ-034 Order: write 8'h71, 8'h77, 8'h65, then pop 3 times -> rd_data shows 71, 77, 65 in order; empty=1 afterwards; key_total=3.
REQ-035 Zero filter: in_valid with in_data 8'h00 four times -> count=0, key_total=0, overflow=0.
REQ-036 Overflow: DEPTH=8; write 9 codes 8'h61..8'h69 -> full=1, count=8, overflow=1, key_total=8; pop 8 -> rd_data 61..68 in order and 69 is absent; then clr_ovf -> overflow=0.
REQ-037 Simultaneous: when full, write 8'h0d together with a pop -> count stays 8, overflow=0, and 8'h0d is the 8th code popped; when empty, write with rd_en -> count=1.
REQ-038 Wrap and reset: stream 20 codes with interleaved pops -> order preserved; assert reset mid-stream -> empty=1 immediately, without waiting for a clk edge.
